// File: rtl/sram_pkg.sv
// Shared constants and types for the 6T bit-cell array access controller.
// Holds the default array/word geometry, the controller state encoding and
// the pin levels that leave the array quiet (no write, no read selection).
package sram_pkg;

    localparam int ADDR_W = 6;                  // array bit-address width
    localparam int WORD_W = 8;                  // host word width
    localparam int BIT_W  = $clog2(WORD_W);     // bit index within a word
    localparam int WA_W   = ADDR_W - BIT_W;     // host word-address width

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WR   = 2'd1,
        RD   = 2'd2
    } state_t;

    // Quiet array pins: write path off, word line off, bit-line-bar precharged.
    localparam logic IDLE_WRITE_EN = 1'b0;
    localparam logic IDLE_WB       = 1'b0;
    localparam logic IDLE_WL       = 1'b0;
    localparam logic IDLE_BLB      = 1'b1;

endpackage

// File: rtl/sram_6t_ctrl.sv
// Host-to-array controller: one word request becomes WORD_W single-bit array
//   accesses, LSB first; busy for WORD_W cycles, reads respond WORD_W edges after accept.
// Backpressure: req_ready is high only in IDLE; responses/wr_done are unthrottled pulses.
// Ports: clk/reset_n (sync, active-low); req_* host request with valid/ready;
//   rsp_valid/rsp_rdata read response; wr_done write completion;
//   sram_* drive the bit-cell array pins, sram_data_out returns the selected bit.
module sram_6t_ctrl #(
    parameter int ADDR_W = sram_pkg::ADDR_W,
    parameter int WORD_W = sram_pkg::WORD_W
) (
    input  logic                               clk,
    input  logic                               reset_n,
    input  logic                               req_valid,
    output logic                               req_ready,
    input  logic                               req_we,
    input  logic [ADDR_W-$clog2(WORD_W)-1:0]   req_addr,
    input  logic [WORD_W-1:0]                  req_wdata,
    output logic                               rsp_valid,
    output logic [WORD_W-1:0]                  rsp_rdata,
    output logic                               wr_done,
    output logic                               sram_write_en,
    output logic                               sram_wb,
    output logic                               sram_data_in,
    output logic                               sram_wl,
    output logic                               sram_blb,
    output logic [ADDR_W-1:0]                  sram_addr,
    input  logic                               sram_data_out
);
    import sram_pkg::*;

    localparam int CNT_W   = $clog2(WORD_W);
    localparam int WADDR_W = ADDR_W - CNT_W;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WORD_W - 1);

    state_t              state;
    logic [CNT_W-1:0]    cnt;
    logic [CNT_W-1:0]    cnt_nxt;
    logic [WADDR_W-1:0]  wa_q;
    logic [WORD_W-1:0]   wdata_q;
    // Holds bits 0..WORD_W-2; the last bit is merged straight into rsp_rdata.
    logic [WORD_W-2:0]   shreg;

    // Only used while cnt < LAST, so it never wraps into the next word.
    assign cnt_nxt = cnt + CNT_W'(1);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state         <= IDLE;
            cnt           <= '0;
            wa_q          <= '0;
            wdata_q       <= '0;
            shreg         <= '0;
            req_ready     <= 1'b1;
            rsp_valid     <= 1'b0;
            wr_done       <= 1'b0;
            rsp_rdata     <= '0;
            sram_write_en <= IDLE_WRITE_EN;
            sram_wb       <= IDLE_WB;
            sram_wl       <= IDLE_WL;
            sram_blb      <= IDLE_BLB;
            sram_addr     <= '0;
            sram_data_in  <= 1'b0;
        end else begin
            rsp_valid <= 1'b0;
            wr_done   <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid && req_ready) begin
                        wa_q      <= req_addr;
                        wdata_q   <= req_wdata;
                        cnt       <= '0;
                        req_ready <= 1'b0;
                        sram_addr <= {req_addr, CNT_W'(0)};
                        if (req_we) begin
                            state         <= WR;
                            sram_write_en <= 1'b1;
                            sram_wb       <= 1'b1;
                            sram_data_in  <= req_wdata[0];
                        end else begin
                            state    <= RD;
                            sram_wl  <= 1'b1;
                            sram_blb <= 1'b0;
                        end
                    end
                end
                WR: begin
                    // The array commits the currently driven bit on this edge.
                    if (cnt == LAST) begin
                        state         <= IDLE;
                        sram_write_en <= IDLE_WRITE_EN;
                        sram_wb       <= IDLE_WB;
                        wr_done       <= 1'b1;
                        req_ready     <= 1'b1;
                    end else begin
                        cnt          <= cnt_nxt;
                        sram_addr    <= {wa_q, cnt_nxt};
                        sram_data_in <= wdata_q[cnt_nxt];
                    end
                end
                RD: begin
                    // Bit cnt is on sram_data_out during the cycle ending at this edge.
                    if (cnt == LAST) begin
                        state     <= IDLE;
                        rsp_rdata <= {sram_data_out, shreg};
                        rsp_valid <= 1'b1;
                        sram_wl   <= IDLE_WL;
                        sram_blb  <= IDLE_BLB;
                        req_ready <= 1'b1;
                    end else begin
                        // Shift right so the first sampled bit ends up at bit 0.
                        shreg     <= (shreg >> 1)
                                   | ((WORD_W-1)'(sram_data_out) << (WORD_W - 2));
                        cnt       <= cnt_nxt;
                        sram_addr <= {wa_q, cnt_nxt};
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sram_6t_ctrl.sv
// Bench for sram_6t_ctrl driving a behavioural 64x1 bit-cell array load.
module tb_sram_6t_ctrl;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       req_valid;
    logic       req_ready;
    logic       req_we;
    logic [2:0] req_addr;
    logic [7:0] req_wdata;
    logic       rsp_valid;
    logic [7:0] rsp_rdata;
    logic       wr_done;
    logic       sram_write_en;
    logic       sram_wb;
    logic       sram_data_in;
    logic       sram_wl;
    logic       sram_blb;
    logic [5:0] sram_addr;
    wire        sram_data_out;

    int checks = 0;
    int errors = 0;
    logic [7:0] last_rd = 8'h00;
    bit mon_en = 1'b0;

    always #5 clk = ~clk;

    sram_6t_ctrl dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_we        (req_we),
        .req_addr      (req_addr),
        .req_wdata     (req_wdata),
        .rsp_valid     (rsp_valid),
        .rsp_rdata     (rsp_rdata),
        .wr_done       (wr_done),
        .sram_write_en (sram_write_en),
        .sram_wb       (sram_wb),
        .sram_data_in  (sram_data_in),
        .sram_wl       (sram_wl),
        .sram_blb      (sram_blb),
        .sram_addr     (sram_addr),
        .sram_data_out (sram_data_out)
    );

    // Bit-cell array load: clears on reset, commits on write_en&wb, drives only when read-selected.
    logic [63:0] mem;
    always @(posedge clk) begin
        if (!reset_n) mem <= '0;
        else if (sram_write_en && sram_wb) mem[sram_addr] <= sram_data_in;
    end
    assign sram_data_out = (sram_wl && !sram_blb) ? mem[sram_addr] : 1'bz;

    // Pin-conflict and pulse-width monitor.
    logic prev_rsp = 1'b0;
    logic prev_wrd = 1'b0;
    always @(negedge clk) begin
        if (mon_en) begin
            checks++;
            if (sram_wl && !sram_blb && sram_write_en && sram_wb) begin
                errors++;
                $display("FAIL pin_conflict t=%0t: read and write selected together", $time);
            end
            checks++;
            if ((rsp_valid && prev_rsp) || (wr_done && prev_wrd)) begin
                errors++;
                $display("FAIL pulse_width t=%0t: rsp_valid=%b/%b wr_done=%b/%b (prev/now), need single-cycle",
                         $time, prev_rsp, rsp_valid, prev_wrd, wr_done);
            end
        end
        prev_rsp = rsp_valid;
        prev_wrd = wr_done;
    end

    // All tasks start and end at a sample point, 1 time unit after a rising edge.
    task automatic wait_ready();
        int n = 0;
        while (req_ready !== 1'b1 && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL wait_ready: req_ready=%b after %0d cycles, need 1", req_ready, n);
        end
    endtask

    task automatic do_write(input logic [2:0] a, input logic [7:0] d, input bit hold, input bit noise);
        wait_ready();
        req_valid = 1'b1; req_we = 1'b1; req_addr = a; req_wdata = d;
        @(posedge clk); #1;                         // after acceptance edge E0
        if (!hold) req_valid = 1'b0;
        for (int j = 0; j < 8; j++) begin
            checks++;
            if (sram_write_en !== 1'b1 || sram_wb !== 1'b1 || sram_wl !== 1'b0 ||
                sram_addr !== {a, 3'(j)} || sram_data_in !== d[j] ||
                req_ready !== 1'b0 || wr_done !== 1'b0 || rsp_valid !== 1'b0) begin
                errors++;
                $display("FAIL write_bit%0d a=%0d: we=%b wb=%b wl=%b addr=%0d din=%b rdy=%b done=%b, need 1 1 0 %0d %b 0 0",
                         j, a, sram_write_en, sram_wb, sram_wl, sram_addr, sram_data_in,
                         req_ready, wr_done, {a, 3'(j)}, d[j]);
            end
            if (noise) begin
                req_valid = 1'b1;
                req_we    = j[0];
                req_addr  = a ^ 3'(j + 1);
                req_wdata = ~d ^ 8'(j);
            end
            @(posedge clk); #1;
        end
        // Now after E8.
        if (!hold) req_valid = 1'b0;
        checks++;
        if (wr_done !== 1'b1 || req_ready !== 1'b1 || sram_write_en !== 1'b0 ||
            sram_wb !== 1'b0 || rsp_valid !== 1'b0 || rsp_rdata !== last_rd) begin
            errors++;
            $display("FAIL write_done a=%0d: done=%b rdy=%b we=%b wb=%b rsp=%b rdata=%h, need 1 1 0 0 0 %h",
                     a, wr_done, req_ready, sram_write_en, sram_wb, rsp_valid, rsp_rdata, last_rd);
        end
    endtask

    task automatic do_read(input logic [2:0] a, input logic [7:0] exp, input bit hold);
        wait_ready();
        req_valid = 1'b1; req_we = 1'b0; req_addr = a; req_wdata = 8'h5A;
        @(posedge clk); #1;
        if (!hold) req_valid = 1'b0;
        for (int j = 0; j < 8; j++) begin
            checks++;
            if (sram_wl !== 1'b1 || sram_blb !== 1'b0 || sram_write_en !== 1'b0 ||
                sram_wb !== 1'b0 || sram_addr !== {a, 3'(j)} ||
                req_ready !== 1'b0 || rsp_valid !== 1'b0 || wr_done !== 1'b0) begin
                errors++;
                $display("FAIL read_bit%0d a=%0d: wl=%b blb=%b we=%b wb=%b addr=%0d rdy=%b rsp=%b, need 1 0 0 0 %0d 0 0",
                         j, a, sram_wl, sram_blb, sram_write_en, sram_wb, sram_addr,
                         req_ready, rsp_valid, {a, 3'(j)});
            end
            @(posedge clk); #1;
        end
        if (!hold) req_valid = 1'b0;
        checks++;
        if (rsp_valid !== 1'b1 || rsp_rdata !== exp || req_ready !== 1'b1 ||
            sram_wl !== 1'b0 || sram_blb !== 1'b1 || wr_done !== 1'b0) begin
            errors++;
            $display("FAIL read_rsp a=%0d: rsp=%b rdata=%h rdy=%b wl=%b blb=%b done=%b, need 1 %h 1 0 1 0",
                     a, rsp_valid, rsp_rdata, req_ready, sram_wl, sram_blb, wr_done, exp);
        end
        last_rd = exp;
    endtask

    task automatic check_reset_vals(input string tag);
        checks++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || wr_done !== 1'b0 ||
            rsp_rdata !== 8'h00 || sram_write_en !== 1'b0 || sram_wb !== 1'b0 ||
            sram_wl !== 1'b0 || sram_blb !== 1'b1 || sram_addr !== 6'd0 ||
            sram_data_in !== 1'b0) begin
            errors++;
            $display("FAIL %s: rdy=%b rsp=%b done=%b rdata=%h we=%b wb=%b wl=%b blb=%b addr=%0d din=%b, need 1 0 0 00 0 0 0 1 0 0",
                     tag, req_ready, rsp_valid, wr_done, rsp_rdata, sram_write_en, sram_wb,
                     sram_wl, sram_blb, sram_addr, sram_data_in);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_vals("reset_values");
        reset_n = 1'b1;
        mon_en  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            checks++;
            if (req_ready !== 1'b1 || sram_wl !== 1'b0 || sram_blb !== 1'b1 ||
                sram_write_en !== 1'b0 || rsp_valid !== 1'b0 || wr_done !== 1'b0) begin
                errors++;
                $display("FAIL idle_cycle%0d: rdy=%b wl=%b blb=%b we=%b rsp=%b done=%b, need 1 0 1 0 0 0",
                         i, req_ready, sram_wl, sram_blb, sram_write_en, rsp_valid, wr_done);
            end
        end
        do_read(3'd0, 8'h00, 1'b0);
    endtask

    task automatic test_write_read();
        do_write(3'd3, 8'hA5, 1'b0, 1'b0);
        do_read(3'd3, 8'hA5, 1'b0);
    endtask

    task automatic test_back_to_back();
        do_write(3'd0, 8'h3C, 1'b1, 1'b0);
        do_write(3'd7, 8'hFF, 1'b1, 1'b0);
        do_read(3'd0, 8'h3C, 1'b1);
        do_read(3'd7, 8'hFF, 1'b0);
        for (int w = 1; w <= 6; w++) begin
            if (w == 3) do_read(3'(w), 8'hA5, 1'b0);
            else        do_read(3'(w), 8'h00, 1'b0);
        end
    endtask

    task automatic test_busy_noise();
        do_write(3'd5, 8'h96, 1'b0, 1'b1);
        do_read(3'd5, 8'h96, 1'b0);
        do_read(3'd4, 8'h00, 1'b0);
    endtask

    task automatic test_reset_mid_write();
        wait_ready();
        req_valid = 1'b1; req_we = 1'b1; req_addr = 3'd2; req_wdata = 8'hFF;
        @(posedge clk); #1;                         // after E0, bit 0 driven
        req_valid = 1'b0;
        repeat (3) begin @(posedge clk); #1; end    // after E3, bit 3 driven
        reset_n = 1'b0;
        @(posedge clk); #1;
        check_reset_vals("reset_mid_write");
        reset_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            checks++;
            if (wr_done !== 1'b0 || sram_write_en !== 1'b0 || req_ready !== 1'b1) begin
                errors++;
                $display("FAIL after_abort%0d: done=%b we=%b rdy=%b, need 0 0 1",
                         i, wr_done, sram_write_en, req_ready);
            end
        end
        last_rd = 8'h00;
        do_read(3'd2, 8'h00, 1'b0);
        do_read(3'd7, 8'h00, 1'b0);
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_back_to_back();
        test_busy_noise();
        test_reset_mid_write();
        repeat (2) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
